// File: rtl/alu_fun.sv
// alu_fun: registered 8-op ALU, 1-cycle latency with valid; zero/ovf flags when ALU_FUN_FLAGS_EN is defined
module alu_fun #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   input  logic             in_valid,
   output logic [WIDTH:0]   outp,
   output logic             out_valid
`ifdef ALU_FUN_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);
   logic [WIDTH:0] ae, be, res;
   assign ae = {1'b0, a};
   assign be = {1'b0, b};
   always_comb begin
      res = sel == 3'd0 ? ae + be :
            sel == 3'd1 ? ae - be :
            sel == 3'd2 ? (ae & be) :
            sel == 3'd3 ? (ae | be) :
            sel == 3'd4 ? (ae ^ be) :
            sel == 3'd5 ? {1'b0, ~a} :
            sel == 3'd6 ? {a, 1'b0} :
                          ae >> 1;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         outp      <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) outp <= res;
      end
   end
`ifdef ALU_FUN_FLAGS_EN
   logic ovf_c;
   // signed overflow shows up as the WIDTH-bit result sign disagreeing with a's sign
   assign ovf_c = sel == 3'd0 ? (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]) :
                  sel == 3'd1 ? (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]) :
                                1'b0;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero <= 1'b0;
         ovf  <= 1'b0;
      end else if (in_valid) begin
         zero <= res == '0;
         ovf  <= ovf_c;
      end
   end
`endif
endmodule

// File: tb/tb_alu_fun.sv
// tb_alu_fun: directed vector table plus randomized run against an arithmetic reference model
module tb_alu_fun;
   localparam int W = 4;
   localparam int M = 1 << (W + 1);
   logic clk = 1'b0;
   logic rst_n, in_valid, out_valid;
   logic [W-1:0] a, b;
   logic [2:0] sel;
   logic [W:0] outp;
`ifdef ALU_FUN_FLAGS_EN
   logic zero, ovf;
`endif
   int n_chk = 0;
   int n_fail = 0;

   alu_fun #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel),
      .in_valid(in_valid), .outp(outp), .out_valid(out_valid)
`ifdef ALU_FUN_FLAGS_EN
      , .zero(zero), .ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rn, vin;
      logic [W-1:0] a, b;
      logic [2:0] sel;
      logic [W:0] eo;
      logic ev, ez, eov;
   } vec_t;
   vec_t tv[24];

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sgn(input int v);
      return v >= (1 << (W - 1)) ? v - (1 << W) : v;
   endfunction

   function automatic int model(input int x, input int y, input int s);
      case (s)
         0: return (x + y) % M;
         1: return (x - y + M) % M;
         2: return x & y;
         3: return x | y;
         4: return x ^ y;
         5: return (1 << W) - 1 - x;
         6: return x * 2;
         default: return x / 2;
      endcase
   endfunction

   function automatic bit model_ovf(input int x, input int y, input int s);
      int r;
      r = s == 0 ? sgn(x) + sgn(y) : sgn(x) - sgn(y);
      return (s <= 1) && (r < -(1 << (W - 1)) || r >= (1 << (W - 1)));
   endfunction

   initial begin
      int eo, ev, ez, eov;
      tv[0]  = '{0, 1, 4'hF, 4'hF, 3'd0, 5'h00, 0, 0, 0};
      tv[1]  = '{0, 1, 4'hF, 4'hF, 3'd0, 5'h00, 0, 0, 0};
      tv[2]  = '{1, 1, 4'hF, 4'h1, 3'd0, 5'h10, 1, 0, 0};
      tv[3]  = '{1, 1, 4'hF, 4'h1, 3'd1, 5'h0E, 1, 0, 0};
      tv[4]  = '{1, 1, 4'hF, 4'h1, 3'd2, 5'h01, 1, 0, 0};
      tv[5]  = '{1, 1, 4'hF, 4'h1, 3'd3, 5'h0F, 1, 0, 0};
      tv[6]  = '{1, 1, 4'hF, 4'h1, 3'd4, 5'h0E, 1, 0, 0};
      tv[7]  = '{1, 1, 4'hF, 4'h1, 3'd5, 5'h00, 1, 1, 0};
      tv[8]  = '{1, 1, 4'hF, 4'h1, 3'd6, 5'h1E, 1, 0, 0};
      tv[9]  = '{1, 1, 4'hF, 4'h1, 3'd7, 5'h07, 1, 0, 0};
      tv[10] = '{1, 1, 4'h0, 4'h1, 3'd1, 5'h1F, 1, 0, 0};
      tv[11] = '{1, 1, 4'hF, 4'h0, 3'd0, 5'h0F, 1, 0, 0};
      tv[12] = '{1, 1, 4'h3, 4'h4, 3'd0, 5'h07, 1, 0, 0};
      tv[13] = '{1, 0, 4'hF, 4'hF, 3'd0, 5'h07, 0, 0, 0};
      tv[14] = '{1, 1, 4'hA, 4'h5, 3'd0, 5'h0F, 1, 0, 0};
      tv[15] = '{1, 1, 4'hA, 4'h5, 3'd1, 5'h05, 1, 0, 1};
      tv[16] = '{1, 1, 4'hA, 4'h5, 3'd0, 5'h0F, 1, 0, 0};
      tv[17] = '{1, 1, 4'hA, 4'h5, 3'd1, 5'h05, 1, 0, 1};
      tv[18] = '{1, 1, 4'h7, 4'h1, 3'd0, 5'h08, 1, 0, 1};
      tv[19] = '{1, 1, 4'h5, 4'h5, 3'd1, 5'h00, 1, 1, 0};
      tv[20] = '{1, 1, 4'hF, 4'hF, 3'd4, 5'h00, 1, 1, 0};
      tv[21] = '{1, 0, 4'h1, 4'h1, 3'd0, 5'h00, 0, 1, 0};
      tv[22] = '{0, 1, 4'h1, 4'h1, 3'd0, 5'h00, 0, 0, 0};
      tv[23] = '{1, 1, 4'h1, 4'h1, 3'd0, 5'h02, 1, 0, 0};
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sel = '0;
      #1;
      for (int i = 0; i < 24; i++) begin
         rst_n = tv[i].rn; in_valid = tv[i].vin; a = tv[i].a; b = tv[i].b; sel = tv[i].sel;
         step();
         chk($sformatf("vec%0d outp", i), 32'(outp), 32'(tv[i].eo));
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(tv[i].ev));
`ifdef ALU_FUN_FLAGS_EN
         chk($sformatf("vec%0d zero", i), 32'(zero), 32'(tv[i].ez));
         chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(tv[i].eov));
`endif
      end
      eo = 2; ev = 1; ez = 0; eov = 0;
      for (int i = 0; i < 400; i++) begin
         rst_n = $urandom_range(0, 15) != 0;
         in_valid = $urandom_range(0, 3) != 0;
         a = W'($urandom); b = W'($urandom); sel = 3'($urandom);
         if (!rst_n) begin
            eo = 0; ev = 0; ez = 0; eov = 0;
         end else if (in_valid) begin
            eo = model(int'(a), int'(b), int'(sel)); ev = 1;
            ez = eo == 0; eov = model_ovf(int'(a), int'(b), int'(sel));
         end else ev = 0;
         step();
         chk($sformatf("rnd%0d outp", i), 32'(outp), 32'(eo));
         chk($sformatf("rnd%0d out_valid", i), 32'(out_valid), 32'(ev));
`ifdef ALU_FUN_FLAGS_EN
         chk($sformatf("rnd%0d zero", i), 32'(zero), 32'(ez));
         chk($sformatf("rnd%0d ovf", i), 32'(ovf), 32'(eov));
`endif
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_fun.md
Name: alu_fun

Overview:
- Registered 8-function integer ALU: two WIDTH-bit operands, 3-bit opcode, WIDTH+1-bit result (MSB carries carry/borrow/shift-out).
- General-purpose datapath leaf; one clock domain, one-cycle registered latency, with a valid strobe travelling alongside the result.

Parameters:
- WIDTH, 4, operand width in bits; result width is WIDTH+1; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sel  input  3  opcode
- in_valid  input  1  operands/opcode qualify this cycle
- outp  output  WIDTH+1  registered result
- out_valid  output  1  outp holds the result of an in_valid cycle

Behaviour:
- Reset: on a rising clk with rst_n=0, outp<=0 and out_valid<=0. Reset dominates in_valid.
- Latency: exactly 1 cycle. A rising edge with rst_n=1 and in_valid=1 loads outp with f(a,b,sel) and sets out_valid<=1.
- Rising edge with rst_n=1 and in_valid=0: outp holds its previous value, and out_valid<=0.
- No backpressure; a new operation may be issued every cycle.
- All arithmetic is unsigned. Zero-extend to WIDTH+1 bits and wrap modulo 2^(WIDTH+1).
- Opcodes:
  - 000 ADD: {0,a}+{0,b}; MSB = carry out.
  - 001 SUB: {0,a}-{0,b}; MSB = 1 iff a<b (borrow), e.g. 0-1 = 11111.
  - 010 AND: {0, a&b}
  - 011 OR: {0, a|b}
  - 100 XOR: {0, a^b}
  - 101 NOT: {0, ~a}; b is ignored.
  - 110 SHL: {a,1'b0}; the MSB of a lands in outp[WIDTH].
  - 111 SHR: {0, a>>1} (logical shift); b is ignored.
- No illegal opcodes exist. X/Z on inputs is not handled beyond simulation semantics.
- Mid-operation reset: a result pending from the same edge is discarded and both outputs clear.

Optional Feature:
- Macro ALU_FUN_FLAGS_EN.
- When defined, the block adds two registered outputs with the same timing and reset (0) as outp, updated only when in_valid=1:
  - zero (1 bit): set iff the full WIDTH+1-bit result == 0.
  - ovf (1 bit): two's-complement overflow of the WIDTH-bit signed interpretation for ADD/SUB, 0 for all other opcodes.
    - ADD: ovf = a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
    - SUB: ovf = a[MSB]!=b[MSB] and diff[MSB]!=a[MSB].
- When undefined, the ports and logic are absent and the functional behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=1111, b=1111 -> outp=00000, out_valid=0. Release; the next edge produces a result.
- Opcode sweep, a=1111 b=0001, in_valid=1, expected outp one cycle after each sel:
  - 000 -> 10000
  - 001 -> 01110
  - 010 -> 00001
  - 011 -> 01111
  - 100 -> 01110
  - 101 -> 00000
  - 110 -> 11110
  - 111 -> 00111
- Borrow/zero operand: a=0000 b=0001 sel=001 -> 11111. a=1111 b=0000 sel=000 -> 01111.
- Valid gating: issue ADD 0011+0100 (-> 00111), then drop in_valid with a=1111, b=1111 -> outp stays 00111 and out_valid falls to 0 one cycle later.
- Back-to-back throughput: alternate sel 000/001 every cycle with a=1010, b=0101 -> outp alternates 01111/00101, out_valid is continuously 1.
- With ALU_FUN_FLAGS_EN:
  - ADD 0111+0001 -> outp 01000, ovf=1, zero=0.
  - SUB 0101-0101 -> outp 00000, zero=1, ovf=0.
  - XOR 1111^1111 -> zero=1, ovf=0.
